alu_acc_stage: RTL and testbench

ALU_ACC_STAGE -- requirements
Module: alu_acc_stage

---
 rtl/alu_acc_stage_if.sv | 27 ++
 rtl/alu_acc_stage.sv | 154 +++++++++++++++
 tb/tb_alu_acc_stage.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_acc_stage_if.sv
// Command, adder and response signals of the accumulator stage.
// The slave side is the stage itself; the master side is the command source, the adder and the consumer.
interface alu_acc_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] operand;
    logic [7:0] add_A;
    logic [7:0] add_B;
    logic       add_C;
    logic [7:0] add_result;
    logic       add_Co;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc;
    logic [3:0] flags;

    modport slave (
        input  in_valid, op, operand, add_result, add_Co, out_ready,
        output in_ready, add_A, add_B, add_C, out_valid, acc, flags
    );

    modport master (
        output in_valid, op, operand, add_result, add_Co, out_ready,
        input  in_ready, add_A, add_B, add_C, out_valid, acc, flags
    );
endinterface

// File: rtl/alu_acc_stage.sv
// 8-bit accumulator stage (IDLE->EXEC->RESP) around an external adder; ACC_OVERFLOW_FLAG_EN enables the V flag.
// Result valid two edges after acceptance; one command per 3 cycles; RESP holds until out_ready, inputs ignored meanwhile.
module alu_acc_stage (
    input  logic           clk,
    input  logic           rst,
    alu_acc_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ADC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_op;
    logic [7:0] r_operand;
    logic [7:0] r_acc;
    logic       r_z;
    logic       r_n;
    logic       r_c;
    logic       r_out_valid;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_exec;
    logic       w_resp_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_exec       = 1'b0;
        w_resp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec       = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    w_resp_done  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Command is captured only on acceptance, so input wiggles in EXEC/RESP cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_LOAD;
            r_operand <= 8'h00;
        end else if (w_accept) begin
            r_op      <= bus.op;
            r_operand <= bus.operand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 8'h00;
            r_z   <= 1'b0;
            r_n   <= 1'b0;
            r_c   <= 1'b0;
        end else if (w_exec) begin
            case (r_op)
                OP_LOAD: begin
                    r_acc <= r_operand;
                    r_z   <= (r_operand == 8'h00);
                    r_n   <= r_operand[7];
                end
                OP_ADD, OP_ADC: begin
                    r_acc <= bus.add_result;
                    r_z   <= (bus.add_result == 8'h00);
                    r_n   <= bus.add_result[7];
                    r_c   <= bus.add_Co;
                end
                default: begin
                    r_acc <= 8'h00;
                    r_z   <= 1'b1;
                    r_n   <= 1'b0;
                    r_c   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_exec) begin
            r_out_valid <= 1'b1;
        end else if (w_resp_done) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef ACC_OVERFLOW_FLAG_EN
    logic r_v;
    logic w_v_next;

    // Signed overflow: like-signed operands producing a result of the other sign.
    always_comb begin
        w_v_next = (r_acc[7] == r_operand[7]) && (bus.add_result[7] != r_acc[7]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= 1'b0;
        end else if (w_exec) begin
            if ((r_op == OP_ADD) || (r_op == OP_ADC)) begin
                r_v <= w_v_next;
            end else begin
                r_v <= 1'b0;
            end
        end
    end

    assign bus.flags = {r_z, r_n, r_c, r_v};
`else
    assign bus.flags = {r_z, r_n, r_c, 1'b0};
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.acc       = r_acc;
    assign bus.add_A     = r_acc;
    assign bus.add_B     = r_operand;
    // Carry only enters through C, which is what lets ADC chain bytes.
    assign bus.add_C     = (r_op == OP_ADC) && r_c;
endmodule

// File: tb/tb_alu_acc_stage.sv
// Self-checking bench for alu_acc_stage: behavioural adder, reference model and scoreboard queue.
module tb_alu_acc_stage;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ADC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef struct packed {
        logic [7:0] acc;
        logic [3:0] flags;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   acc_cyc;
    exp_t sb[$];
    logic [7:0] m_acc;
    logic [3:0] m_flags;

    alu_acc_stage_if bus();

    alu_acc_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External 8-bit adder.
    assign {bus.add_Co, bus.add_result} = {1'b0, bus.add_A} + {1'b0, bus.add_B} + {8'h00, bus.add_C};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_step(input logic [1:0] op, input logic [7:0] opnd);
        logic [8:0] s;
        logic       cin;
        case (op)
            OP_LOAD: begin
                m_acc   = opnd;
                m_flags = {(opnd == 8'h00), opnd[7], m_flags[1], 1'b0};
            end
            OP_ADD, OP_ADC: begin
                cin = (op == OP_ADC) ? m_flags[1] : 1'b0;
                s   = {1'b0, m_acc} + {1'b0, opnd} + {8'h00, cin};
`ifdef ACC_OVERFLOW_FLAG_EN
                m_flags = {(s[7:0] == 8'h00), s[7], s[8], (m_acc[7] == opnd[7]) && (s[7] != m_acc[7])};
`else
                m_flags = {(s[7:0] == 8'h00), s[7], s[8], 1'b0};
`endif
                m_acc = s[7:0];
            end
            default: begin
                m_acc   = 8'h00;
                m_flags = 4'b1000;
            end
        endcase
    endtask

    // Presents a command until accepted; returns at the negedge after acceptance (DUT in EXEC).
    task automatic issue(input logic [1:0] op, input logic [7:0] opnd);
        int n;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.operand  = opnd;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL issue_timeout in_ready=%b required=1", bus.in_ready);
        end else begin
            model_step(op, opnd);
            sb.push_back({m_acc, m_flags});
        end
        @(negedge clk);
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.operand  = 8'($urandom);
    endtask

    // Counts edges since acceptance until out_valid is seen (bounded).
    task automatic await_resp(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] opnd,
                           output int lat, output logic [7:0] o_acc, output logic [3:0] o_flags);
        bus.out_ready = 1'b1;
        issue(op, opnd);
        await_resp(lat);
        o_acc   = bus.acc;
        o_flags = bus.flags;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        m_acc   = 8'h00;
        m_flags = 4'b0000;
        sb.delete();
        n_checks++;
        if ({bus.acc, bus.flags, bus.out_valid} !== 13'h0) $display("FAIL reset_state acc=%h flags=%b out_valid=%b required 00/0000/0", bus.acc, bus.flags, bus.out_valid);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_overflow;
        int lat; logic [7:0] a; logic [3:0] f; exp_t e;
        run_cmd(OP_LOAD, 8'h7F, lat, a, f);
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== e) $display("FAIL ovf_load got %h/%b required %h/%b", a, f, e.acc, e.flags);
        else n_pass++;
        run_cmd(OP_ADD, 8'h01, lat, a, f);
        e = sb.pop_front();
        n_checks++;
`ifdef ACC_OVERFLOW_FLAG_EN
        if ({a, f} !== {8'h80, 4'b0101} || e !== {8'h80, 4'b0101}) $display("FAIL ovf_add got %h/%b required 80/0101", a, f);
`else
        if ({a, f} !== {8'h80, 4'b0100} || e !== {8'h80, 4'b0100}) $display("FAIL ovf_add got %h/%b required 80/0100", a, f);
`endif
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL ovf_latency got %0d required 2", lat);
        else n_pass++;
    endtask

    task automatic test_carry_zero;
        int lat; logic [7:0] a; logic [3:0] f; exp_t e;
        run_cmd(OP_LOAD, 8'h01, lat, a, f);
        e = sb.pop_front();
        run_cmd(OP_ADD, 8'hFF, lat, a, f);
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== {8'h00, 4'b1010} || e !== {8'h00, 4'b1010}) $display("FAIL cz_add got %h/%b required 00/1010", a, f);
        else n_pass++;
        run_cmd(OP_ADC, 8'h00, lat, a, f);
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== {8'h01, 4'b0000} || e !== {8'h01, 4'b0000}) $display("FAIL cz_adc got %h/%b required 01/0000", a, f);
        else n_pass++;
    endtask

    task automatic test_chain;
        int lat; logic [7:0] a; logic [3:0] f; exp_t e;
        run_cmd(OP_LOAD, 8'hFF, lat, a, f);
        e = sb.pop_front();
        run_cmd(OP_ADD, 8'h01, lat, a, f);
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== {8'h00, 4'b1010} || e !== {8'h00, 4'b1010}) $display("FAIL chain_lo got %h/%b required 00/1010", a, f);
        else n_pass++;
        run_cmd(OP_LOAD, 8'h01, lat, a, f);
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== {8'h01, 4'b0010} || e !== {8'h01, 4'b0010}) $display("FAIL chain_load_keeps_c got %h/%b required 01/0010", a, f);
        else n_pass++;
        run_cmd(OP_ADC, 8'h00, lat, a, f);
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== {8'h02, 4'b0000} || e !== {8'h02, 4'b0000}) $display("FAIL chain_hi got %h/%b required 02/0000", a, f);
        else n_pass++;
    endtask

    task automatic test_clr;
        int lat; logic [7:0] a; logic [3:0] f; exp_t e;
        run_cmd(OP_LOAD, 8'hFF, lat, a, f);
        e = sb.pop_front();
        run_cmd(OP_ADD, 8'h01, lat, a, f);
        e = sb.pop_front();
        run_cmd(OP_CLR, 8'h5A, lat, a, f);
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== {8'h00, 4'b1000} || e !== {8'h00, 4'b1000}) $display("FAIL clr_result got %h/%b required 00/1000", a, f);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL clr_latency got %0d required 2", lat);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int lat; logic [7:0] a; logic [3:0] f; exp_t e;
        bus.out_ready = 1'b0;
        issue(OP_LOAD, 8'h55);
        await_resp(lat);
        a = bus.acc;
        f = bus.flags;
        e = sb.pop_front();
        n_checks++;
        if ({a, f} !== e || lat !== 2) $display("FAIL bp_result got %h/%b lat %0d required %h/%b lat 2", a, f, lat, e.acc, e.flags);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.op       = OP_CLR;
                bus.operand  = 8'hAA;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc !== a || bus.flags !== f)
                $display("FAIL bp_hold cyc%0d out_valid=%b in_ready=%b acc=%h flags=%b required 1/0/%h/%b", i, bus.out_valid, bus.in_ready, bus.acc, bus.flags, a, f);
            else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.acc !== 8'h55)
            $display("FAIL bp_release in_ready=%b out_valid=%b acc=%h required 1/0/55", bus.in_ready, bus.out_valid, bus.acc);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat; int hits; logic [7:0] a; logic [3:0] f; exp_t e;
        run_cmd(OP_LOAD, 8'h20, lat, a, f);
        e = sb.pop_front();
        issue(OP_ADD, 8'h10);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.acc, bus.flags, bus.out_valid, bus.in_ready} !== {8'h00, 4'b0000, 1'b0, 1'b1})
            $display("FAIL rst_mid acc=%h flags=%b out_valid=%b in_ready=%b required 00/0000/0/1", bus.acc, bus.flags, bus.out_valid, bus.in_ready);
        else n_pass++;
        rst = 1'b0;
        sb.delete();
        m_acc   = 8'h00;
        m_flags = 4'b0000;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) hits++;
        end
        n_checks++;
        if (hits !== 0) $display("FAIL rst_mid_no_resp stray cycles=%0d required 0", hits);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat; int prev; logic [7:0] a; logic [3:0] f; exp_t e; logic [1:0] op; logic [7:0] d;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_CLR && $urandom_range(0, 2) != 0) op = OP_ADC;
            d = 8'($urandom);
            run_cmd(op, d, lat, a, f);
            e = sb.pop_front();
            n_checks++;
            if ({a, f} !== e) $display("FAIL b2b_result%0d op=%0d opnd=%h got %h/%b required %h/%b", i, op, d, a, f, e.acc, e.flags);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (acc_cyc - prev !== 3) $display("FAIL b2b_spacing%0d got %0d required 3", i, acc_cyc - prev);
                else n_pass++;
            end
            prev = acc_cyc;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        cyc           = 0;
        acc_cyc       = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_LOAD;
        bus.operand   = 8'h00;
        bus.out_ready = 1'b1;
        test_reset();
        test_overflow();
        test_carry_zero();
        test_chain();
        test_clr();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
